led_cmd_tx: RTL
===============

// Module: led_cmd_tx
// PURPOSE
//  Buffered valid/ready stream transmitter: the sending end of the LED command link into slaveAXI.
//  Software/fabric logic pushes DATA_W-bit LED codes into a local FIFO.
//  The block presents them one beat at a time on valid/data and obeys ready from the receiver.
//  Sits between the command source and slaveAXI; replaces direct dataIn/inValid drive when burst loading is needed.
// PARAMETERS
//  DATA_W  2  width of one LED command code
//  DEPTH   4  FIFO entries, power of two >= 2; the output register is extra, so total storage = DEPTH+1
// PORTS
//  clk       in   1                 system clock; all logic on rising edge
//  rst       in   1                 synchronous reset, active-high
//  wr_data   in   DATA_W            command code to enqueue
//  wr_en     in   1                 enqueue strobe, one entry per cycle
//  full      out  1                 FIFO holds DEPTH entries
//  overflow  out  1                 sticky: a write was dropped; cleared only by rst
//  level     out  $clog2(DEPTH)+2   FIFO count + output-register occupancy, range 0..DEPTH+1
//  tick      in   1                 single-cycle pace pulse in clk domain (used only with pacing)
//  valid     out  1                 output beat present
//  data      out  DATA_W            output beat payload
//  ready     in   1                 receiver accepts beat when valid&&ready
// BEHAVIOUR
//  Reset: valid=0, data=0, full=0, overflow=0, level=0; FIFO pointers/count=0.
//  Reset has priority over every other event. Stored and in-flight beats are discarded. valid=0 after the edge regardless of ready.
//  Write: at an edge where wr_en=1 and full=0, wr_data enters the FIFO tail.
//  Write when full: full is sampled before the edge. wr_en with full=1 is dropped even if a pop happens the same cycle. overflow<=1.
//  Output register: loads from the FIFO head at an edge when the FIFO is non-empty and load_ok=1,
//   AND (valid=0 OR ready=1).
//  load_ok is 1 without the pacing macro; see CONFIGURATION.
//  Transfer: valid&&ready at an edge completes the beat.
//   If no new load occurs at the same edge, valid<=0.
//   If a new load occurs, valid stays 1 and data takes the next code. Back-to-back throughput is 1 beat/cycle.
//  Stability: while valid=1 and ready=0, data and valid are held unchanged.
//  Bypass: none. A write into an empty FIFO at edge N loads the output register at edge N+1. valid is high after edge N+1.
//  Empty FIFO, simultaneous write and load opportunity: the write lands in the FIFO and the load waits one cycle.
//  A simultaneous push and pop with full=0 leaves the FIFO count unchanged.
//  Pointers wrap modulo DEPTH; the count is tracked separately, so full and empty are never ambiguous.
//  full = (fifo_count==DEPTH); level = fifo_count + valid, both registered.
//  ready while valid=0 is ignored.
// CONFIGURATION
//  LED_CMD_TX_PACE_EN defined: load_ok = tick. At most one beat leaves the FIFO per tick pulse.
//   Each beat is held on valid until accepted; the next beat loads only on a later tick with valid=0 or ready=1.
//   Drives the 1 Hz LED stepping from the clockDivider pulse.
//  LED_CMD_TX_PACE_EN undefined: load_ok = 1. The tick port is present but ignored, and the FIFO drains at receiver rate.
// TESTING
//  1 Reset: rst=1 for 2 cycles with wr_en=1 -> valid=0, full=0, level=0, overflow=0 throughout.
//  2 Single beat: write 2'b10 with ready=0 -> valid=1 one cycle later, data=2'b10 held 5 cycles.
//    Then ready=1 -> valid=0 next cycle and level goes 1->0.
//  3 Burst: ready=1, write 0,1,2,3 on consecutive cycles -> data 0,1,2,3 on consecutive cycles, no gaps.
//  4 Overflow: ready=0, write 6 codes -> first five stored (1 output + 4 FIFO), full=1, level=5.
//    6th dropped, overflow=1 sticky. Draining yields exactly the first 5 codes in order.
//  5 Full plus pop: full=1, ready=1, and wr_en=1 in the same cycle -> the write is dropped, overflow=1, level 5->4.
//  6 Pacing (macro on): preload 3 codes, ready=1, tick every 8 cycles -> exactly one beat per tick.
//    Each beat is valid 1 cycle, in order. Macro off: all 3 drain back-to-back.

Source files
------------

// File: rtl/led_cmd_tx_if.sv
// LED command link bundle: write side (wr_*/full/overflow/level), pace tick, and output stream (valid/data/ready).
// master = transmitter side (drives status and the stream), slave = command source plus receiver side.
// Signals are plain wires; all timing is owned by led_cmd_tx.
interface led_cmd_tx_if #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
);
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_en;
    logic                     full;
    logic                     overflow;
    logic [$clog2(DEPTH)+1:0] level;
    logic                     tick;
    logic                     valid;
    logic [DATA_W-1:0]        data;
    logic                     ready;

    modport master (
        input  wr_data, wr_en, tick, ready,
        output full, overflow, level, valid, data
    );

    modport slave (
        output wr_data, wr_en, tick, ready,
        input  full, overflow, level, valid, data
    );
endinterface

// File: rtl/led_cmd_tx.sv
// LED command transmitter: DEPTH-entry FIFO feeding a registered valid/data output stage; LED_CMD_TX_PACE_EN gates loads on tick.
// Latency: a write at edge N appears on valid/data after edge N+1 (no bypass); 1 beat/cycle back-to-back when unpaced.
// Backpressure: valid/data held while ready=0; writes while full are dropped and latch the sticky overflow flag.
module led_cmd_tx #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    led_cmd_tx_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = $clog2(DEPTH) + 2;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic [LW-1:0]     level_q, level_d;

    logic push;
    logic load;
    logic load_ok;

`ifdef LED_CMD_TX_PACE_EN
    // Paced build: at most one beat leaves the FIFO per tick pulse.
    assign load_ok = bus.tick;
`else
    // Unpaced build: tick is intentionally ignored; the FIFO drains at receiver rate.
    logic unused_tick;
    assign unused_tick = bus.tick;
    assign load_ok     = 1'b1;
`endif

    // Next-state: push/load decisions, FIFO storage, pointers, count, output stage and status.
    always_comb begin
        // full is the registered flag, so a write while full is dropped even if a pop happens this cycle
        push = bus.wr_en && !full_q;
        // load uses the pre-edge count: a write into an empty FIFO cannot load at the same edge
        load = (count_q != '0) && load_ok && (!valid_q || bus.ready);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        data_d   = data_q;

        if (push) begin
            mem_d[wr_ptr_q] = bus.wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end

        if (load) begin
            data_d   = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end

        if (push && !load) begin
            count_d = count_q + CW'(1);
        end else if (!push && load) begin
            count_d = count_q - CW'(1);
        end

        full_d     = (count_d == CW'(DEPTH));
        level_d    = LW'(count_d) + LW'(valid_d);
        overflow_d = overflow_q || (bus.wr_en && full_q);
    end

    // State register with synchronous reset discarding all stored and in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            level_q    <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            level_q    <= level_d;
        end
    end

    // All outputs come straight from flops.
    assign bus.valid    = valid_q;
    assign bus.data     = data_q;
    assign bus.full     = full_q;
    assign bus.overflow = overflow_q;
    assign bus.level    = level_q;
endmodule
